// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the MIPS debug controllers: request-selector width,
// controller ID map, index-width helpers and the frame/padding arithmetic used
// by every controller that streams a wide word as fixed-size frames.
// No ports (package).
// -----------------------------------------------------------------------------
package debug_pkg;

    localparam int NB_REQUEST_SELECT = 6;

    // Controller ID map. ID_NONE is never a valid controller and doubles as
    // the "no previous request" value of every request-edge detector.
    localparam logic [NB_REQUEST_SELECT-1:0] ID_NONE                  = 6'h3F;
    localparam logic [NB_REQUEST_SELECT-1:0] ID_FRAME_SERIALIZER_BASE = 6'h00;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result = 0;
        int v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Width of an index selecting one of `count` items, never narrower than 1.
    function automatic int nb_index(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

    // Number of nb_frame-bit frames needed to carry nb_data bits.
    function automatic int n_words(input int nb_data, input int nb_frame);
        return (nb_data + nb_frame - 1) / nb_frame;
    endfunction

    // Zero bits added above the data to fill the last frame.
    function automatic int nb_padding(input int nb_data, input int nb_frame);
        return n_words(nb_data, nb_frame) * nb_frame - nb_data;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } serializer_state_t;

endpackage

// File: rtl/debug_request_decode.sv
// -----------------------------------------------------------------------------
// debug_request_decode
// Decodes the debug interface request selector against a contiguous range of
// controller IDs and flags a new request whenever the selector moves onto an
// in-range ID different from the one seen on the previous clock.
//
// Ports:
//   i_clock           clock, all state on posedge
//   i_reset_n         asynchronous active-low reset
//   i_request_select  request ID from the debug interface
//   o_edge            new in-range request this cycle (combinational)
//   o_channel         channel index (selector - base), valid with o_edge
// -----------------------------------------------------------------------------
module debug_request_decode
    import debug_pkg::*;
#(
    parameter int                           N_CHANNELS         = 4,
    parameter logic [NB_REQUEST_SELECT-1:0] CONTROLLER_ID_BASE = ID_FRAME_SERIALIZER_BASE,
    parameter int                           NB_CH              = nb_index(N_CHANNELS)
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic [NB_REQUEST_SELECT-1:0] i_request_select,
    output logic                         o_edge,
    output logic [NB_CH-1:0]             o_channel
);

    localparam int                  NB_OFFSET  = NB_REQUEST_SELECT + 1;
    localparam logic [NB_OFFSET-1:0] N_CH_LIMIT = NB_OFFSET'(N_CHANNELS);

    logic [NB_REQUEST_SELECT-1:0] r_sel_prev;
    logic [NB_OFFSET-1:0]         w_offset;
    logic                         w_in_range;

    // Resetting to ID_NONE makes a selector held on a valid ID through reset
    // look like a fresh request once reset is released.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of the others; blocking here would create order races.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sel_prev <= ID_NONE;
        end else begin
            r_sel_prev <= i_request_select;
        end
    end

    // One extra bit turns the two-sided range test into a single unsigned
    // compare: selectors below the base wrap to a large offset.
    assign w_offset   = {1'b0, i_request_select} - {1'b0, CONTROLLER_ID_BASE};
    assign w_in_range = (w_offset < N_CH_LIMIT);
    assign o_edge     = w_in_range && (i_request_select != r_sel_prev);
    assign o_channel  = w_offset[NB_CH-1:0];

endmodule

// File: rtl/debug_frame_serializer.sv
// -----------------------------------------------------------------------------
// debug_frame_serializer
// Multi-channel debug latch controller. A new request snapshots the selected
// channel's data word and streams it LSB frame first over a valid/ready link,
// marking the final frame. One request arriving mid-transfer is parked in a
// single pending slot (newest wins) and served back-to-back with no bubble.
//
// Ports:
//   i_clock               clock, all state on posedge
//   i_reset_n             asynchronous active-low reset
//   i_request_select      request ID from the debug interface
//   i_data_from_mips      N_CHANNELS packed data words, channel k at k*NB_INPUT_SIZE
//   i_ready               interface accepts the current frame
//   o_frame_to_interface  current frame, zero while o_valid is low
//   o_valid               frame valid
//   o_last                current frame is the final frame of the snapshot
//   o_channel             channel being sent
//   o_busy                transfer in progress or request pending
//   o_done                one-cycle pulse after the final frame handshake
//   o_overrun             one-cycle pulse after a pending request is replaced
// -----------------------------------------------------------------------------
module debug_frame_serializer
    import debug_pkg::*;
#(
    parameter int                           NB_LATCH           = 32,
    parameter int                           NB_INPUT_SIZE      = 64,
    parameter int                           N_CHANNELS         = 4,
    parameter logic [NB_REQUEST_SELECT-1:0] CONTROLLER_ID_BASE = ID_FRAME_SERIALIZER_BASE,
    localparam int                          NB_CH              = nb_index(N_CHANNELS)
) (
    input  logic                                i_clock,
    input  logic                                i_reset_n,
    input  logic [NB_REQUEST_SELECT-1:0]        i_request_select,
    input  logic [N_CHANNELS*NB_INPUT_SIZE-1:0] i_data_from_mips,
    input  logic                                i_ready,
    output logic [NB_LATCH-1:0]                 o_frame_to_interface,
    output logic                                o_valid,
    output logic                                o_last,
    output logic [NB_CH-1:0]                    o_channel,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_overrun
);

    localparam int              N_WORDS    = n_words(NB_INPUT_SIZE, NB_LATCH);
    localparam int              NB_PADDING = nb_padding(NB_INPUT_SIZE, NB_LATCH);
    localparam int              NB_SNAP    = N_WORDS * NB_LATCH;
    localparam int              NB_PTR     = nb_index(N_WORDS);
    localparam logic [NB_PTR-1:0] PTR_LAST = NB_PTR'(N_WORDS - 1);

    // The top ID must stay below ID_NONE, otherwise the post-reset edge
    // detection on that channel would be lost.
    generate
        if ((N_CHANNELS < 1) ||
            (int'(CONTROLLER_ID_BASE) + N_CHANNELS - 1 >= int'(ID_NONE))) begin : g_bad_id_map
            $error("debug_frame_serializer: controller ID range overlaps ID_NONE or is empty");
        end
    endgenerate

    serializer_state_t  r_state, w_state_next;
    logic [NB_PTR-1:0]  r_ptr, w_ptr_next;
    logic [NB_SNAP-1:0] r_snapshot, w_snapshot_next;
    logic [NB_CH-1:0]   r_channel, w_channel_next;
    logic               r_pend_valid, w_pend_valid_next;
    logic [NB_CH-1:0]   r_pend_ch, w_pend_ch_next;
    logic               r_done, w_done_next;
    logic               r_overrun, w_overrun_next;

    logic                     w_edge;
    logic [NB_CH-1:0]         w_edge_ch;
    logic                     w_sending;
    logic                     w_handshake;
    logic                     w_final;
    logic                     w_load;
    logic [NB_CH-1:0]         w_serve_ch;
    logic [NB_INPUT_SIZE-1:0] w_serve_data;
    logic [NB_SNAP-1:0]       w_serve_snap;
    logic [NB_LATCH-1:0]      w_word;

    debug_request_decode #(
        .N_CHANNELS         (N_CHANNELS),
        .CONTROLLER_ID_BASE (CONTROLLER_ID_BASE),
        .NB_CH              (NB_CH)
    ) u_decode (
        .i_clock          (i_clock),
        .i_reset_n        (i_reset_n),
        .i_request_select (i_request_select),
        .o_edge           (w_edge),
        .o_channel        (w_edge_ch)
    );

    assign w_sending   = (r_state == ST_SEND);
    assign w_handshake = w_sending && i_ready;
    assign w_final     = w_handshake && (r_ptr == PTR_LAST);

    // A fresh edge always beats the pending slot; the slot is only consulted
    // on the final handshake when no new request arrives in the same cycle.
    assign w_serve_ch = (w_final && !w_edge) ? r_pend_ch : w_edge_ch;

    always_comb begin
        w_serve_data = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (w_serve_ch == NB_CH'(c)) begin
                w_serve_data = i_data_from_mips[c*NB_INPUT_SIZE +: NB_INPUT_SIZE];
            end
        end
    end

    generate
        if (NB_PADDING > 0) begin : g_pad
            assign w_serve_snap = {{NB_PADDING{1'b0}}, w_serve_data};
        end else begin : g_no_pad
            assign w_serve_snap = w_serve_data;
        end
    endgenerate

    always_comb begin
        w_word = '0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (r_ptr == NB_PTR'(w)) begin
                w_word = r_snapshot[w*NB_LATCH +: NB_LATCH];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            // NOTE: the snapshot is a plain register bank, not a RAM, so it
            // takes the async reset like any other flop and never holds
            // stale channel data across a reset.
            r_snapshot   <= '0;
            r_channel    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_ch    <= '0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ptr        <= w_ptr_next;
            r_snapshot   <= w_snapshot_next;
            r_channel    <= w_channel_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_ch    <= w_pend_ch_next;
            r_done       <= w_done_next;
            r_overrun    <= w_overrun_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // skipped one would infer a latch.
        w_state_next      = r_state;
        w_ptr_next        = r_ptr;
        w_snapshot_next   = r_snapshot;
        w_channel_next    = r_channel;
        w_pend_valid_next = r_pend_valid;
        w_pend_ch_next    = r_pend_ch;
        w_done_next       = 1'b0;
        w_overrun_next    = 1'b0;
        w_load            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_final) begin
                    w_done_next = 1'b1;
                    if (w_edge) begin
                        w_load = 1'b1;
                    end else if (r_pend_valid) begin
                        w_load            = 1'b1;
                        w_pend_valid_next = 1'b0;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    if (w_handshake) begin
                        w_ptr_next = r_ptr + 1'b1;
                    end
                    if (w_edge) begin
                        w_overrun_next    = r_pend_valid;
                        w_pend_valid_next = 1'b1;
                        w_pend_ch_next    = w_edge_ch;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Data is sampled live when service starts, not when a request is parked.
        if (w_load) begin
            w_snapshot_next = w_serve_snap;
            w_ptr_next      = '0;
            w_channel_next  = w_serve_ch;
        end
    end

    assign o_valid              = w_sending;
    assign o_frame_to_interface = w_sending ? w_word : '0;
    assign o_last               = w_sending && (r_ptr == PTR_LAST);
    assign o_channel            = r_channel;
    assign o_busy               = w_sending || r_pend_valid;
    assign o_done               = r_done;
    assign o_overrun            = r_overrun;

endmodule

// File: tb/tb_debug_frame_serializer.sv
module tb_debug_frame_serializer;
    import debug_pkg::*;

    typedef struct packed {
        logic [31:0] frame;
        logic        last;
        logic [1:0]  channel;
    } exp64_t;

    typedef struct packed {
        logic [31:0] frame;
        logic        last;
        logic [0:0]  channel;
    } exp40_t;

    logic clk;
    logic rst_n;

    // Main instance: 64-bit words, 4 channels, base 0.
    logic [5:0]   sel;
    logic [255:0] data;
    logic         ready;
    logic [31:0]  frame;
    logic         valid, last, busy, done, overrun;
    logic [1:0]   channel;

    // Second instance: 40-bit words, 2 channels, base 0x10.
    logic [5:0]  sel40;
    logic [79:0] data40;
    logic        ready40;
    logic [31:0] frame40;
    logic        valid40, last40, busy40, done40, overrun40;
    logic [0:0]  ch40;

    int total = 0;
    int bad   = 0;

    exp64_t q64[$];
    exp40_t q40[$];
    exp64_t mon_e64;
    exp40_t mon_e40;

    int          vcnt64 = 0, ovr64 = 0, vcnt40 = 0;
    logic        prev_final64 = 0, prev_stall64 = 0, prev_final40 = 0;
    logic [31:0] prev_frame64;
    logic [1:0]  prev_ch64;

    int base_v, base_o, n;

    debug_frame_serializer #(
        .NB_LATCH           (32),
        .NB_INPUT_SIZE      (64),
        .N_CHANNELS         (4),
        .CONTROLLER_ID_BASE (6'h00)
    ) dut (
        .i_clock              (clk),
        .i_reset_n            (rst_n),
        .i_request_select     (sel),
        .i_data_from_mips     (data),
        .i_ready              (ready),
        .o_frame_to_interface (frame),
        .o_valid              (valid),
        .o_last               (last),
        .o_channel            (channel),
        .o_busy               (busy),
        .o_done               (done),
        .o_overrun            (overrun)
    );

    debug_frame_serializer #(
        .NB_LATCH           (32),
        .NB_INPUT_SIZE      (40),
        .N_CHANNELS         (2),
        .CONTROLLER_ID_BASE (6'h10)
    ) dut40 (
        .i_clock              (clk),
        .i_reset_n            (rst_n),
        .i_request_select     (sel40),
        .i_data_from_mips     (data40),
        .i_ready              (ready40),
        .o_frame_to_interface (frame40),
        .o_valid              (valid40),
        .o_last               (last40),
        .o_channel            (ch40),
        .o_busy               (busy40),
        .o_done               (done40),
        .o_overrun            (overrun40)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push64(input logic [31:0] f, input logic l, input logic [1:0] c);
        exp64_t e;
        e.frame = f; e.last = l; e.channel = c;
        q64.push_back(e);
    endtask

    task automatic push40(input logic [31:0] f, input logic l, input logic [0:0] c);
        exp40_t e;
        e.frame = f; e.last = l; e.channel = c;
        q40.push_back(e);
    endtask

    task automatic wait_idle64(input string name, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || q64.size() != 0) && k < budget);
        check(name, 64'(busy || q64.size() != 0), 64'd0);
    endtask

    task automatic wait_idle40(input string name, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy40 || q40.size() != 0) && k < budget);
        check(name, 64'(busy40 || q40.size() != 0), 64'd0);
    endtask

    // Monitor for the 64-bit instance: scoreboard on every handshake, done
    // pulse one cycle after the expected last frame, stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_final64 = 1'b0;
            prev_stall64 = 1'b0;
        end else begin
            if (done || prev_final64) check("done64", 64'(done), 64'(prev_final64));
            if (prev_stall64 && valid) begin
                check("stall_frame", 64'(frame), 64'(prev_frame64));
                check("stall_channel", 64'(channel), 64'(prev_ch64));
            end
            if (valid)   vcnt64++;
            if (overrun) ovr64++;
            prev_final64 = 1'b0;
            if (valid && ready) begin
                if (q64.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame64: got %0h ch %0d expected none", frame, channel);
                end else begin
                    mon_e64 = q64.pop_front();
                    check("frame64", 64'(frame), 64'(mon_e64.frame));
                    check("last64", 64'(last), 64'(mon_e64.last));
                    check("channel64", 64'(channel), 64'(mon_e64.channel));
                    prev_final64 = mon_e64.last;
                end
            end
            prev_stall64 = valid && !ready;
            prev_frame64 = frame;
            prev_ch64    = channel;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_final40 = 1'b0;
        end else begin
            if (done40 || prev_final40) check("done40", 64'(done40), 64'(prev_final40));
            if (valid40) vcnt40++;
            prev_final40 = 1'b0;
            if (valid40 && ready40) begin
                if (q40.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame40: got %0h expected none", frame40);
                end else begin
                    mon_e40 = q40.pop_front();
                    check("frame40", 64'(frame40), 64'(mon_e40.frame));
                    check("last40", 64'(last40), 64'(mon_e40.last));
                    check("channel40", 64'(ch40), 64'(mon_e40.channel));
                    prev_final40 = mon_e40.last;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        sel     = 6'h3F;
        ready   = 1'b1;
        data    = {64'hCAFEBABE_87654321, 64'hDEADBEEF_01234567,
                   64'h11111111_22222222, 64'h00C0FFEE_0BADF00D};
        sel40   = 6'h3F;
        ready40 = 1'b1;
        data40  = {40'hAB_12345678, 40'h55_AABBCCDD};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_frame", 64'(frame), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        check("rst_channel", 64'(channel), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic transfer of channel 2, one-cycle latency
        push64(32'h01234567, 1'b0, 2'd2);
        push64(32'hDEADBEEF, 1'b1, 2'd2);
        sel = 6'h02;
        check("latency_before", 64'(valid), 64'd0);
        @(posedge clk);
        #1;
        check("latency_valid", 64'(valid), 64'd1);
        check("latency_channel", 64'(channel), 64'd2);
        wait_idle64("idle_basic", 10);

        // Selector held steady: no second transfer
        base_v = vcnt64;
        repeat (5) @(negedge clk);
        check("steady_no_repeat", 64'(vcnt64 - base_v), 64'd0);
        check("idle_frame_zero", 64'(frame), 64'd0);

        // Backpressure: 3 stalled cycles on frame 0
        @(posedge clk);
        #1;
        base_v = vcnt64;
        ready  = 1'b0;
        sel    = 6'h00;
        push64(32'h0BADF00D, 1'b0, 2'd0);
        push64(32'h00C0FFEE, 1'b1, 2'd0);
        repeat (4) @(posedge clk);
        #1;
        ready = 1'b1;
        wait_idle64("idle_backpressure", 10);
        check("bp_valid_cycles", 64'(vcnt64 - base_v), 64'd5);

        // Overrun: ch1 then ch3 arrive during ch0, ch3 follows with no bubble
        @(posedge clk);
        #1;
        sel = 6'h3F;
        @(posedge clk);
        #1;
        base_o = ovr64;
        ready  = 1'b0;
        sel    = 6'h00;
        push64(32'h0BADF00D, 1'b0, 2'd0);
        push64(32'h00C0FFEE, 1'b1, 2'd0);
        push64(32'h87654321, 1'b0, 2'd3);
        push64(32'hCAFEBABE, 1'b1, 2'd3);
        @(posedge clk);
        #1;
        sel = 6'h01;
        @(posedge clk);
        #1;
        sel = 6'h03;
        @(posedge clk);
        #1;
        check("overrun_pulse", 64'(overrun), 64'd1);
        ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 10);
        check("no_bubble_valid", 64'(valid), 64'd1);
        check("no_bubble_channel", 64'(channel), 64'd3);
        wait_idle64("idle_overrun", 10);
        check("overrun_count", 64'(ovr64 - base_o), 64'd1);

        // Out-of-range ID (BASE + N_CHANNELS)
        @(posedge clk);
        #1;
        base_v = vcnt64;
        sel    = 6'h04;
        repeat (6) @(negedge clk);
        check("oor_no_valid", 64'(vcnt64 - base_v), 64'd0);
        check("oor_not_busy", 64'(busy), 64'd0);

        // Reset during frame 1, selector held through release
        @(posedge clk);
        #1;
        sel = 6'h02;
        push64(32'h01234567, 1'b0, 2'd2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_reset_last", 64'(last), 64'd1);
        ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(valid), 64'd0);
        check("async_frame", 64'(frame), 64'd0);
        check("async_last", 64'(last), 64'd0);
        check("async_channel", 64'(channel), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        push64(32'h01234567, 1'b0, 2'd2);
        push64(32'hDEADBEEF, 1'b1, 2'd2);
        rst_n = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("fresh_frame0", 64'(frame), 64'h01234567);
        wait_idle64("idle_after_reset", 10);

        // 40-bit instance with base 0x10
        @(posedge clk);
        #1;
        base_v = vcnt40;
        sel40  = 6'h0F;
        repeat (3) @(negedge clk);
        check("d40_below_base", 64'(vcnt40 - base_v), 64'd0);
        @(posedge clk);
        #1;
        push40(32'h12345678, 1'b0, 1'b1);
        push40(32'h000000AB, 1'b1, 1'b1);
        sel40 = 6'h11;
        @(posedge clk);
        #1;
        check("d40_channel", 64'(ch40), 64'd1);
        wait_idle40("idle_d40", 10);
        check("d40_valid_cycles", 64'(vcnt40 - base_v), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
